node_interface: RTL and testbench

// - Per-node network interface between one PE and the local port (port 0) of its mesh router.
// - Injection side: buffers PE packets in a TX FIFO and drives i_data/i_data_val of the router

---
 rtl/node_interface.sv | 208 ++++++++++++++++++++
 tb/tb_node_interface.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/node_interface.sv
// node_interface
//   Network interface between one PE and the local port (port 0) of its mesh
//   router.
//   - Injection: PE packets are buffered in a TX FIFO. Each packet is presented
//     to the router for exactly one cycle, once the router's local-port enable
//     is nonzero.
//   - Ejection: router port-0 output is captured into an RX FIFO that the PE
//     drains with a ready/valid handshake. The router cannot be backpressured,
//     so a packet that arrives while the RX FIFO is full is dropped and counted.
//   - A flush FSM stops accepting PE packets and drains the TX FIFO. It is used
//     before the network is reconfigured.
//
// Handshakes:
//   PE -> TX : a packet transfers at a rising edge where i_pe_val & o_pe_rdy.
//              o_pe_rdy is a register, so it never depends on i_pe_val.
//   RX -> PE : a packet transfers at a rising edge where o_rx_val & i_rx_rdy.
//              o_rx_data is the FIFO head and is stable while o_rx_val is high.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   i_pe_data/i_pe_val    packet from the PE
//   o_pe_rdy              TX FIFO accepts a packet (registered)
//   o_net_data/o_net_val  to router local i_data / i_data_val (registered)
//   i_net_en              router local-port o_en; nonzero means inject allowed
//   i_net_data/i_net_val  from router local o_data / o_data_val
//   o_rx_data/o_rx_val    RX FIFO head toward the PE
//   i_rx_rdy              PE consumes the RX head
//   i_flush               drain request (level, sampled only in RUN)
//   o_flush_done          one-cycle pulse when a drain completes
//   o_tx_cnt/o_rx_cnt/o_drop_cnt  saturating traffic counters
//   o_dbg_state           current FSM state (0 = RUN, 1 = FLUSH)
module node_interface #(
  parameter int PKT_W    = 64,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PKT_W-1:0] i_pe_data,
  input  logic             i_pe_val,
  output logic             o_pe_rdy,
  output logic [PKT_W-1:0] o_net_data,
  output logic             o_net_val,
  input  logic [3:0]       i_net_en,
  input  logic [PKT_W-1:0] i_net_data,
  input  logic             i_net_val,
  output logic [PKT_W-1:0] o_rx_data,
  output logic             o_rx_val,
  input  logic             i_rx_rdy,
  input  logic             i_flush,
  output logic             o_flush_done,
  output logic [CNT_W-1:0] o_tx_cnt,
  output logic [CNT_W-1:0] o_rx_cnt,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic             o_dbg_state
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_CW = RX_AW + 1;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  // ---------------- registers ----------------
  state_t             r_state;
  logic               r_pe_rdy;
  logic               r_flush_done;
  logic [PKT_W-1:0]   r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]   r_tx_wr;
  logic [TX_AW-1:0]   r_tx_rd;
  logic [TX_CW-1:0]   r_tx_count;
  logic [PKT_W-1:0]   r_net_data;
  logic               r_net_val;
  logic [PKT_W-1:0]   r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]   r_rx_wr;
  logic [RX_AW-1:0]   r_rx_rd;
  logic [RX_CW-1:0]   r_rx_count;
  logic [CNT_W-1:0]   r_tx_cnt;
  logic [CNT_W-1:0]   r_rx_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;

  // ---------------- next-state wires ----------------
  logic               w_tx_push;
  logic               w_tx_pop;
  logic [TX_CW-1:0]   w_tx_count_nxt;
  state_t             w_state_nxt;
  logic               w_flush_done_nxt;
  logic               w_rx_full;
  logic               w_rx_pop;
  logic               w_rx_wr;
  logic               w_rx_drop;

  assign w_tx_push = i_pe_val & r_pe_rdy;
  assign w_tx_pop  = (r_tx_count != '0) & (i_net_en != 4'b0000);

  assign w_rx_full = (r_rx_count == RX_CW'(RX_DEPTH));
  assign w_rx_pop  = (r_rx_count != '0) & i_rx_rdy;
  // A full RX FIFO still takes the packet when the PE frees a slot at the same edge.
  assign w_rx_wr   = i_net_val & (~w_rx_full | w_rx_pop);
  assign w_rx_drop = i_net_val & ~w_rx_wr;

  always_comb begin
    w_tx_count_nxt = r_tx_count;
    if (w_tx_push && !w_tx_pop) begin
      w_tx_count_nxt = r_tx_count + TX_CW'(1);
    end else if (w_tx_pop && !w_tx_push) begin
      w_tx_count_nxt = r_tx_count - TX_CW'(1);
    end
  end

  // An empty TX FIFO cannot pop, so "empty" alone means the drain is finished.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_done_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_flush) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (r_tx_count == '0) begin
          w_state_nxt      = ST_RUN;
          w_flush_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // ---------------- flush FSM and its registered outputs ----------------
  // o_pe_rdy is loaded with the value that RUN & (count < depth) takes after
  // this edge. It therefore mirrors the registered state and is low in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
      r_pe_rdy     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= w_flush_done_nxt;
      r_pe_rdy     <= (w_state_nxt == ST_RUN) && (w_tx_count_nxt < TX_CW'(TX_DEPTH));
    end
  end

  // ---------------- TX FIFO and injection register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= '0;
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
      r_net_data <= '0;
      r_net_val  <= 1'b0;
      r_tx_cnt   <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wr] <= i_pe_data;
        r_tx_wr           <= r_tx_wr + 1'b1;
      end
      if (w_tx_pop) begin
        r_net_data <= r_tx_mem[r_tx_rd];
        r_tx_rd    <= r_tx_rd + 1'b1;
        if (r_tx_cnt != '1) r_tx_cnt <= r_tx_cnt + 1'b1;
      end
      r_net_val  <= w_tx_pop;
      r_tx_count <= w_tx_count_nxt;
    end
  end

  // ---------------- RX FIFO ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RX_DEPTH; i++) r_rx_mem[i] <= '0;
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_rx_wr) begin
        r_rx_mem[r_rx_wr] <= i_net_data;
        r_rx_wr           <= r_rx_wr + 1'b1;
        if (r_rx_cnt != '1) r_rx_cnt <= r_rx_cnt + 1'b1;
      end
      if (w_rx_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
      if (w_rx_wr && !w_rx_pop) begin
        r_rx_count <= r_rx_count + RX_CW'(1);
      end else if (w_rx_pop && !w_rx_wr) begin
        r_rx_count <= r_rx_count - RX_CW'(1);
      end
    end
  end

  // ---------------- outputs ----------------
  assign o_pe_rdy     = r_pe_rdy;
  assign o_net_data   = r_net_data;
  assign o_net_val    = r_net_val;
  assign o_rx_data    = r_rx_mem[r_rx_rd];
  assign o_rx_val     = (r_rx_count != '0);
  assign o_flush_done = r_flush_done;
  assign o_tx_cnt     = r_tx_cnt;
  assign o_rx_cnt     = r_rx_cnt;
  assign o_drop_cnt   = r_drop_cnt;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_node_interface.sv
module tb_node_interface;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [63:0] pe_data;
  logic        pe_val;
  logic [3:0]  net_en;
  logic [63:0] net_data;
  logic        net_val;
  logic        rx_rdy;
  logic        flush;

  // main DUT (CNT_W = 16)
  logic        pe_rdy, net_val_o, rx_val, flush_done, dbg_state;
  logic [63:0] net_data_o, rx_data;
  logic [15:0] tx_cnt, rx_cnt, drop_cnt;

  // saturation DUT (CNT_W = 2), driven by the same stimulus
  logic        s_pe_rdy, s_net_val_o, s_rx_val, s_flush_done, s_dbg_state;
  logic [63:0] s_net_data_o, s_rx_data;
  logic [1:0]  s_tx_cnt, s_rx_cnt, s_drop_cnt;

  node_interface #(.PKT_W(64), .TX_DEPTH(4), .RX_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .i_pe_data(pe_data), .i_pe_val(pe_val), .o_pe_rdy(pe_rdy),
    .o_net_data(net_data_o), .o_net_val(net_val_o), .i_net_en(net_en),
    .i_net_data(net_data), .i_net_val(net_val),
    .o_rx_data(rx_data), .o_rx_val(rx_val), .i_rx_rdy(rx_rdy),
    .i_flush(flush), .o_flush_done(flush_done),
    .o_tx_cnt(tx_cnt), .o_rx_cnt(rx_cnt), .o_drop_cnt(drop_cnt),
    .o_dbg_state(dbg_state)
  );

  node_interface #(.PKT_W(64), .TX_DEPTH(4), .RX_DEPTH(2), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .i_pe_data(pe_data), .i_pe_val(pe_val), .o_pe_rdy(s_pe_rdy),
    .o_net_data(s_net_data_o), .o_net_val(s_net_val_o), .i_net_en(net_en),
    .i_net_data(net_data), .i_net_val(net_val),
    .o_rx_data(s_rx_data), .o_rx_val(s_rx_val), .i_rx_rdy(rx_rdy),
    .i_flush(flush), .o_flush_done(s_flush_done),
    .o_tx_cnt(s_tx_cnt), .o_rx_cnt(s_rx_cnt), .o_drop_cnt(s_drop_cnt),
    .o_dbg_state(s_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pe_data = '0; pe_val = 1'b0; net_en = 4'b0000;
    net_data = '0; net_val = 1'b0; rx_rdy = 1'b0; flush = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " pe_rdy"},     {63'd0, pe_rdy},     64'd0);
    chk({tag, " net_val"},    {63'd0, net_val_o},  64'd0);
    chk({tag, " net_data"},   net_data_o,          64'd0);
    chk({tag, " rx_val"},     {63'd0, rx_val},     64'd0);
    chk({tag, " flush_done"}, {63'd0, flush_done}, 64'd0);
    chk({tag, " tx_cnt"},     {48'd0, tx_cnt},     64'd0);
    chk({tag, " rx_cnt"},     {48'd0, rx_cnt},     64'd0);
    chk({tag, " drop_cnt"},   {48'd0, drop_cnt},   64'd0);
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    reset = 1'b1;
    tick();
    check_all_zero({tag, " in reset"});
    reset = 1'b0;
    tick();
    chk({tag, " pe_rdy after release"}, {63'd0, pe_rdy}, 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        pe_val;
    logic [63:0] pe_data;
    logic [3:0]  en;
    logic        net_val;
    logic [63:0] net_data;
    logic        rx_rdy;
    logic        e_pe_rdy;
    logic        e_net_val;
    logic [63:0] e_net_data;
    logic [15:0] e_tx_cnt;
    logic        e_rx_val;
    logic [63:0] e_rx_data;
    logic [15:0] e_rx_cnt;
    logic [15:0] e_drop_cnt;
  } vec_t;

  vec_t vq[$];

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Expected values describe the outputs just after the edge at which the
    // row's inputs are applied.
    //            pv  pdata    en    nv  ndata    rr  rdy nv  ndata    txc  rv rdata    rxc drp
    // basic inject: A,B on consecutive edges, 2-cycle latency
    vq.push_back('{1, 64'hA1, 4'h1, 0, 64'h0,  0,  1,  0, 64'h0,  16'd0, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{1, 64'hB2, 4'h1, 0, 64'h0,  0,  1,  1, 64'hA1, 16'd1, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{0, 64'h0,  4'h1, 0, 64'h0,  0,  1,  1, 64'hB2, 16'd2, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{0, 64'h0,  4'h1, 0, 64'h0,  0,  1,  0, 64'hB2, 16'd2, 0, 64'h0,  16'd0, 16'd0});
    // backpressure: en=0, fill 4, 5th refused
    vq.push_back('{1, 64'hC1, 4'h0, 0, 64'h0,  0,  1,  0, 64'hB2, 16'd2, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{1, 64'hC2, 4'h0, 0, 64'h0,  0,  1,  0, 64'hB2, 16'd2, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{1, 64'hC3, 4'h0, 0, 64'h0,  0,  1,  0, 64'hB2, 16'd2, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{1, 64'hC4, 4'h0, 0, 64'h0,  0,  0,  0, 64'hB2, 16'd2, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{1, 64'hC5, 4'h0, 0, 64'h0,  0,  0,  0, 64'hB2, 16'd2, 0, 64'h0,  16'd0, 16'd0});
    // drain with en=4'b1000, strict order
    vq.push_back('{0, 64'h0,  4'h8, 0, 64'h0,  0,  1,  1, 64'hC1, 16'd3, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{0, 64'h0,  4'h8, 0, 64'h0,  0,  1,  1, 64'hC2, 16'd4, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{0, 64'h0,  4'h8, 0, 64'h0,  0,  1,  1, 64'hC3, 16'd5, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{0, 64'h0,  4'h8, 0, 64'h0,  0,  1,  1, 64'hC4, 16'd6, 0, 64'h0,  16'd0, 16'd0});
    vq.push_back('{0, 64'h0,  4'h8, 0, 64'h0,  0,  1,  0, 64'hC4, 16'd6, 0, 64'h0,  16'd0, 16'd0});
    // RX overflow: 3 arrivals with PE stalled, then a 4th while PE pops
    vq.push_back('{0, 64'h0,  4'h0, 1, 64'hD1, 0,  1,  0, 64'hC4, 16'd6, 1, 64'hD1, 16'd1, 16'd0});
    vq.push_back('{0, 64'h0,  4'h0, 1, 64'hD2, 0,  1,  0, 64'hC4, 16'd6, 1, 64'hD1, 16'd2, 16'd0});
    vq.push_back('{0, 64'h0,  4'h0, 1, 64'hD3, 0,  1,  0, 64'hC4, 16'd6, 1, 64'hD1, 16'd2, 16'd1});
    vq.push_back('{0, 64'h0,  4'h0, 1, 64'hD4, 1,  1,  0, 64'hC4, 16'd6, 1, 64'hD2, 16'd3, 16'd1});
    vq.push_back('{0, 64'h0,  4'h0, 0, 64'h0,  1,  1,  0, 64'hC4, 16'd6, 1, 64'hD4, 16'd3, 16'd1});
    vq.push_back('{0, 64'h0,  4'h0, 0, 64'h0,  1,  1,  0, 64'hC4, 16'd6, 0, 64'h0,  16'd3, 16'd1});

    do_reset("init");

    for (int i = 0; i < vq.size(); i++) begin
      pe_val = vq[i].pe_val; pe_data = vq[i].pe_data; net_en = vq[i].en;
      net_val = vq[i].net_val; net_data = vq[i].net_data; rx_rdy = vq[i].rx_rdy;
      tick();
      chk($sformatf("v%0d pe_rdy", i),   {63'd0, pe_rdy},    {63'd0, vq[i].e_pe_rdy});
      chk($sformatf("v%0d net_val", i),  {63'd0, net_val_o}, {63'd0, vq[i].e_net_val});
      chk($sformatf("v%0d net_data", i), net_data_o,         vq[i].e_net_data);
      chk($sformatf("v%0d tx_cnt", i),   {48'd0, tx_cnt},    {48'd0, vq[i].e_tx_cnt});
      chk($sformatf("v%0d rx_val", i),   {63'd0, rx_val},    {63'd0, vq[i].e_rx_val});
      if (vq[i].e_rx_val)
        chk($sformatf("v%0d rx_data", i), rx_data, vq[i].e_rx_data);
      chk($sformatf("v%0d rx_cnt", i),   {48'd0, rx_cnt},    {48'd0, vq[i].e_rx_cnt});
      chk($sformatf("v%0d drop_cnt", i), {48'd0, drop_cnt},  {48'd0, vq[i].e_drop_cnt});
    end

    // ---- reset mid-traffic: queued TX and RX contents are discarded ----
    idle_inputs();
    pe_val = 1'b1; pe_data = 64'hE0; net_val = 1'b1; net_data = 64'hF0;
    tick();
    pe_data = 64'hE1; net_val = 1'b0;
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    net_en = 4'b0001;
    tick();
    chk("midreset pe_rdy after release", {63'd0, pe_rdy}, 64'd1);
    tick();
    chk("midreset no stale tx", {63'd0, net_val_o}, 64'd0);
    chk("midreset no stale rx", {63'd0, rx_val}, 64'd0);

    // ---- flush with 3 queued packets ----
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      pe_val = 1'b1; pe_data = 64'hF1 + 64'(k);
      tick();
    end
    pe_val = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush enter state", {63'd0, dbg_state}, 64'd1);
    chk("flush enter pe_rdy", {63'd0, pe_rdy}, 64'd0);
    pe_val = 1'b1; pe_data = 64'hEF;  // must be refused while flushing
    tick();
    pe_val = 1'b0;
    chk("flush refuse pe_rdy", {63'd0, pe_rdy}, 64'd0);
    net_en = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("flush send%0d val", k), {63'd0, net_val_o}, 64'd1);
      chk($sformatf("flush send%0d data", k), net_data_o, 64'hF1 + 64'(k));
      chk($sformatf("flush send%0d done", k), {63'd0, flush_done}, 64'd0);
      chk($sformatf("flush send%0d pe_rdy", k), {63'd0, pe_rdy}, 64'd0);
    end
    tick();
    chk("flush done pulse", {63'd0, flush_done}, 64'd1);
    chk("flush done no extra send", {63'd0, net_val_o}, 64'd0);
    chk("flush done state run", {63'd0, dbg_state}, 64'd0);
    chk("flush done pe_rdy", {63'd0, pe_rdy}, 64'd1);
    tick();
    chk("flush done one cycle", {63'd0, flush_done}, 64'd0);
    chk("flush tx_cnt", {48'd0, tx_cnt}, 64'd3);

    // ---- flush while already empty: completes one cycle after entry ----
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("eflush enter state", {63'd0, dbg_state}, 64'd1);
    chk("eflush enter done", {63'd0, flush_done}, 64'd0);
    tick();
    chk("eflush done pulse", {63'd0, flush_done}, 64'd1);
    chk("eflush pe_rdy", {63'd0, pe_rdy}, 64'd1);
    tick();
    chk("eflush done clear", {63'd0, flush_done}, 64'd0);

    // ---- counter saturation: 5 injections, CNT_W=2 stays at 3 ----
    do_reset("sat");
    net_en = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      pe_val = 1'b1; pe_data = 64'h50 + 64'(k);
      tick();
    end
    pe_val = 1'b0;
    tick();
    tick();
    chk("sat tx_cnt CNT_W=2", {62'd0, s_tx_cnt}, 64'd3);
    chk("sat tx_cnt CNT_W=16", {48'd0, tx_cnt}, 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
